mdu_seq: RTL and testbench

//  Multi-cycle sequencer for the RV32M multiply/divide unit. Accepts one M-extension
//  op per handshake from decode/issue. MUL* completes in 1 cycle; DIV/REM run a

---
 rtl/mdu_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle sequencer for the RV32M multiply/divide unit.
//
// Accepts one M-extension op per in_valid/in_ready handshake. MUL* results are
// ready one cycle after acceptance. DIV*/REM* run a radix-2 restoring loop of XLEN
// iterations followed by a sign-fix cycle. The result is held in DONE until
// out_ready is seen.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   flush              synchronous abort of any in-flight op
//   in_valid/in_ready  request handshake (in_ready only in IDLE)
//   in_op              function3 (000 MUL .. 111 REMU)
//   in_rs1, in_rs2     operands (dividend/multiplicand, divisor/multiplier)
//   in_rd              destination tag, returned unchanged on out_rd
//   out_valid/out_ready result handshake
//   out_result, out_rd result and its tag
//   busy               high whenever the sequencer is not IDLE
//
// Configuration:
//   MDU_DIV_FASTPATH_EN  when defined, divide-by-zero, signed overflow and
//                        |rs2| > |rs1| bypass the iteration loop.

module mdu_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy
);

    localparam int unsigned     CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    // in_op[2] is encoded by the MUL/DIV state choice, so only the low bits are kept
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             fast_q, fast_d;

    logic              accept;
    logic              in_signed;
    logic [XLEN-1:0]   in_mag1, in_mag2;
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic              div_signed, q_neg, r_neg, ovf;
    logic [XLEN-1:0]   fix_q, fix_r;

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign out_rd     = rd_q;

    // Operand conditioning and datapath helpers
    always_comb begin
        accept    = in_valid & in_ready & ~flush;
        in_signed = ~in_op[0];
        in_mag1   = (in_signed & in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
        in_mag2   = (in_signed & in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;

        // MULH sign-extends both operands, MULHSU only rs1; the low half is identical for all
        mul_sa = rs1_q[XLEN-1] & ((op_q == 2'b01) | (op_q == 2'b10));
        mul_sb = rs2_q[XLEN-1] & (op_q == 2'b01);
        mul_a  = {{XLEN{mul_sa}}, rs1_q};
        mul_b  = {{XLEN{mul_sb}}, rs2_q};
        mul_p  = mul_a * mul_b;

        // Restoring step: the borrow bit of the XLEN+1-bit subtraction decides the quotient bit
        rem_sh  = {rem_q, quot_q[XLEN-1]};
        rem_sub = rem_sh - {1'b0, dvsr_q};

        div_signed = ~op_q[0];
        q_neg      = div_signed & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
        r_neg      = div_signed & rs1_q[XLEN-1];
        ovf        = div_signed & (rs1_q == SMIN) & (rs2_q == '1);

        if (rs2_q == '0) begin
            fix_q = '1;
            fix_r = rs1_q;
        end else if (fast_q) begin
            fix_q = ovf ? SMIN : '0;
            fix_r = ovf ? '0 : rs1_q;
        end else begin
            fix_q = q_neg ? -quot_q : quot_q;
            fix_r = r_neg ? -rem_q : rem_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        fast_d   = fast_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = in_op[1:0];
                    rd_d   = in_rd;
                    rs1_d  = in_rs1;
                    rs2_d  = in_rs2;
                    quot_d = in_mag1;
                    dvsr_d = in_mag2;
                    rem_d  = '0;
                    cnt_d  = '0;
`ifdef MDU_DIV_FASTPATH_EN
                    fast_d = in_op[2] & ((in_rs2 == '0) |
                                         (in_signed & (in_rs1 == SMIN) & (in_rs2 == '1)) |
                                         (in_mag2 > in_mag1));
`else
                    fast_d = 1'b0;
`endif
                    // Bypassed divides still spend one cycle in FIX so the
                    // result appears with the same latency as a multiply.
                    if (!in_op[2]) begin
                        state_d = S_MUL;
                    end else if (fast_d) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (op_q == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            S_DIV: begin
                if (!rem_sub[XLEN]) begin
                    rem_d  = rem_sub[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = op_q[1] ? fix_r : fix_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            fast_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            fast_q   <= fast_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq: scoreboard of expected {result, tag, latency} entries
// pushed at issue time and popped when out_valid is observed.

`timescale 1ns/1ps

module tb_mdu_seq;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam logic [31:0] SMIN  = 32'h8000_0000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op     = '0;
    logic [31:0] in_rs1    = '0;
    logic [31:0] in_rs2    = '0;
    logic [4:0]  in_rd     = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mdu_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb2, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        case (op)
            3'b000: begin p = 64'(ua * ub);  return p[31:0];  end
            3'b001: begin p = 64'(sa * sb2); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub);  return p[63:32]; end
            3'b011: begin p = 64'(ua * ub);  return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
                return 32'(ia / ib);
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'h0 - x) : x;
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
`ifdef MDU_DIV_FASTPATH_EN
        if (b == 0) return 2;
        if (!op[0] && a == SMIN && b == 32'hFFFF_FFFF) return 2;
        if (mag(b, !op[0]) > mag(a, !op[0])) return 2;
`endif
        return 34;
    endfunction

    // Drives one request, records what must come back, returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res);
        exp_t e;
        e.res = exp_res;
        e.rd  = rd;
        e.lat = lat_of(op, a, b);
        sb.push_back(e);
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_rd    = 5'($urandom);
    endtask

    // Counts edges from acceptance (accepting edge = 1) until out_valid, bounded.
    task automatic wait_out(output int edges);
        edges = 1;
        while (out_valid !== 1'b1 && edges < 80) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b%b%b expected 100", in_ready, out_valid, busy);
        end
        n_checks++;
        if (out_result !== 32'h0 || out_rd !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_data: out_result=%h out_rd=%h expected 0/0", out_result, out_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
        logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int   n;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                issue(ops[i], 32'hFFFF_FFFF, 32'd3, 5'(i + 1), exps[i]);
            end else begin
                logic [2:0]  op;
                logic [31:0] a, b;
                op = {1'b0, 2'($urandom)};
                a  = $urandom;
                b  = $urandom;
                issue(op, a, b, 5'(i + 1), model(op, a, b));
            end
            wait_out(n);
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || n != e.lat) begin
                n_fail++;
                $display("FAIL mul_latency[%0d]: out_valid=%b after %0d edges, expected 1 after %0d", i, out_valid, n, e.lat);
            end
            n_checks++;
            if (out_result !== e.res) begin
                n_fail++;
                $display("FAIL mul_result[%0d]: got %h expected %h", i, out_result, e.res);
            end
            n_checks++;
            if (out_rd !== e.rd) begin
                n_fail++;
                $display("FAIL mul_rd[%0d]: got %0d expected %0d", i, out_rd, e.rd);
            end
            ack();
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd7 * 32'd14 + 32'd2};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int   n;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                issue(ops[i], as[i], bs[i], 5'(i + 10), exps[i]);
            end else begin
                logic [2:0]  op;
                logic [31:0] a, b;
                op = {1'b1, 2'($urandom)};
                a  = $urandom;
                b  = (i % 2 == 0) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
                issue(op, a, b, 5'(i + 10), model(op, a, b));
            end
            wait_out(n);
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || n != e.lat) begin
                n_fail++;
                $display("FAIL div_latency[%0d]: out_valid=%b after %0d edges, expected 1 after %0d", i, out_valid, n, e.lat);
            end
            n_checks++;
            if (out_result !== e.res) begin
                n_fail++;
                $display("FAIL div_result[%0d]: got %h expected %h", i, out_result, e.res);
            end
            n_checks++;
            if (out_rd !== e.rd) begin
                n_fail++;
                $display("FAIL div_rd[%0d]: got %0d expected %0d", i, out_rd, e.rd);
            end
            ack();
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [10] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101,
                                  3'b111, 3'b110, 3'b100, 3'b100, 3'b110};
        logic [31:0] as  [10] = '{32'd5, 32'd5, SMIN, SMIN, 32'd5,
                                  32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFD};
        logic [31:0] bs  [10] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                  32'd0, 32'd0, 32'd0, 32'd10, 32'd10};
        logic [31:0] exps[10] = '{32'hFFFF_FFFF, 32'd5, SMIN, 32'd0, 32'hFFFF_FFFF,
                                  32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD};
        int   n;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 20), exps[i]);
            wait_out(n);
            e = sb.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || n != e.lat) begin
                n_fail++;
                $display("FAIL special_latency[%0d]: out_valid=%b after %0d edges, expected 1 after %0d", i, out_valid, n, e.lat);
            end
            n_checks++;
            if (out_result !== e.res) begin
                n_fail++;
                $display("FAIL special_result[%0d]: got %h expected %h", i, out_result, e.res);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        int   n;
        exp_t e;
        issue(3'b000, 32'h0000_1234, 32'h10, 5'd7, 32'h0001_2340);
        wait_out(n);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== e.res || out_rd !== e.rd) begin
            n_fail++;
            $display("FAIL bp_first: valid=%b result=%h rd=%0d expected 1/%h/%0d", out_valid, out_result, out_rd, e.res, e.rd);
        end
        in_op    = 3'b000;
        in_rs1   = 32'd99;
        in_rs2   = 32'd99;
        in_rd    = 5'd9;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== e.res || out_rd !== e.rd || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h rd=%0d in_ready=%b busy=%b expected 1/%h/%0d/0/1",
                         c, out_valid, out_result, out_rd, in_ready, busy, e.res, e.rd);
            end
        end
        in_valid = 1'b0;
        ack();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        int   n;
        int   seen;
        exp_t e;
        issue(3'b100, 32'd1000, 32'd3, 5'd3, 32'd333);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b expected 0/1/0", busy, in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_output: out_valid seen %0d cycles expected 0", seen);
        end
        // flush on the same edge as a request: nothing is accepted
        in_op    = 3'b000;
        in_rs1   = 32'd2;
        in_rs2   = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_accept: busy=%b expected 0", busy);
        end
        issue(3'b000, 32'd6, 32'd7, 5'd11, 32'd42);
        wait_out(n);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || n != e.lat || out_result !== e.res || out_rd !== e.rd) begin
            n_fail++;
            $display("FAIL flush_then_mul: valid=%b edges=%0d result=%h rd=%0d expected 1/%0d/%h/%0d",
                     out_valid, n, out_result, out_rd, e.lat, e.res, e.rd);
        end
        // flush in DONE drops the held result
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        exp_t e;
        issue(3'b101, 32'd77, 32'd5, 5'd17, 32'd15);
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_result !== 32'h0 || out_rd !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready/out_valid/busy=%b%b%b result=%h rd=%0d expected 100/0/0",
                     in_ready, out_valid, busy, out_result, out_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'b101, 32'd9, 32'd3, 5'd21, 32'd3);
        wait_out(n);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || n != e.lat || out_result !== e.res || out_rd !== e.rd) begin
            n_fail++;
            $display("FAIL reset_then_divu: valid=%b edges=%0d result=%h rd=%0d expected 1/%0d/%h/%0d",
                     out_valid, n, out_result, out_rd, e.lat, e.res, e.rd);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        issue(3'b000, 32'd12, 32'd12, 5'd4, 32'd144);
        wait_out(n);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== e.res || out_rd !== e.rd) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b result=%h rd=%0d expected 1/%h/%0d", out_valid, out_result, out_rd, e.res, e.rd);
        end
        e.res = 32'd10;
        e.rd  = 5'd2;
        e.lat = lat_of(3'b101, 32'd50, 32'd5);
        sb.push_back(e);
        in_op     = 3'b101;
        in_rs1    = 32'd50;
        in_rs2    = 32'd5;
        in_rd     = 5'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_handshake_edge: out_valid=%b busy=%b expected 0/0", out_valid, busy);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept_next: busy=%b expected 1", busy);
        end
        wait_out(n);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || n != e.lat || out_result !== e.res || out_rd !== e.rd) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b edges=%0d result=%h rd=%0d expected 1/%0d/%h/%0d",
                     out_valid, n, out_result, out_rd, e.lat, e.res, e.rd);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
